mdu_scheduler: RTL and testbench

//  Sequencing controller for the EX-stage multiply/divide unit (MDU). Owns HI/LO.

---
 rtl/mdu_scheduler.sv | 137 +++++++++++++
 tb/tb_mdu_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_scheduler.sv
// MDU sequencing controller: issues mult/div ops, models latency with a countdown, owns HI/LO.
// Defining MDU_MADD_EN adds the accumulate ops madd/maddu/msub/msubu (codes 5..8).
module mdu_scheduler #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  mul_op,
    input  logic [1:0]  mthilo,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_uses_mdu,
    output logic        busy,
    output logic        stall_d,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
`endif

    typedef enum logic {IDLE, RUN} stateT;

    stateT            state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pendHi;
    logic [31:0]      pendLo;

    logic        legalOp;
    logic        isDiv;
    logic        start;
    logic        divZero;
    logic        divOvf;
    logic [31:0] divisorS;
    logic [31:0] divisorU;
    logic [31:0] quotS;
    logic [31:0] remS;
    logic [31:0] quotU;
    logic [31:0] remU;
    logic [63:0] prodS;
    logic [63:0] prodU;
    logic [63:0] resFull;

`ifdef MDU_MADD_EN
    assign legalOp = (mul_op >= OP_MULT) && (mul_op <= OP_MSUBU);
`else
    assign legalOp = (mul_op >= OP_MULT) && (mul_op <= OP_DIVU);
`endif
    assign isDiv   = (mul_op == OP_DIV) || (mul_op == OP_DIVU);
    assign start   = op_valid && legalOp && (state == IDLE);
    assign busy    = start || (state == RUN);
    assign stall_d = busy && d_uses_mdu;

    // Products are formed at 64 bits so the low 64 bits are exact for both signednesses.
    assign prodS = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign prodU = {32'd0, src_a} * {32'd0, src_b};

    // Divisor is forced to 1 for /0 and the signed overflow case; /1 already yields the overflow result.
    assign divZero  = (src_b == 32'd0);
    assign divOvf   = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    assign divisorS = (divZero || divOvf) ? 32'd1 : src_b;
    assign divisorU = divZero ? 32'd1 : src_b;
    assign quotS    = 32'($signed(src_a) / $signed(divisorS));
    assign remS     = 32'($signed(src_a) % $signed(divisorS));
    assign quotU    = src_a / divisorU;
    assign remU     = src_a % divisorU;

    // Full {hi,lo} result for the op being issued this cycle.
    always_comb begin
        resFull = 64'd0;
        case (mul_op)
            OP_MULT:  resFull = prodS;
            OP_MULTU: resFull = prodU;
            OP_DIV:   resFull = {remS, quotS};
            OP_DIVU:  resFull = {remU, quotU};
`ifdef MDU_MADD_EN
            OP_MADD:  resFull = {hi, lo} + prodS;
            OP_MADDU: resFull = {hi, lo} + prodU;
            OP_MSUB:  resFull = {hi, lo} - prodS;
            OP_MSUBU: resFull = {hi, lo} - prodU;
`endif
            default:  resFull = 64'd0;
        endcase
        if (isDiv && divZero) begin
            resFull = {src_a, 32'hFFFF_FFFF};
        end
    end

    // Issue/countdown FSM; HI/LO commit on the last busy cycle's edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            pendHi <= 32'd0;
            pendLo <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pendHi <= resFull[63:32];
                        pendLo <= resFull[31:0];
                        cnt    <= isDiv ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                        state  <= RUN;
                    end else if (op_valid) begin
                        if (mthilo == 2'd1) begin
                            lo <= src_a;
                        end else if (mthilo == 2'd2) begin
                            hi <= src_a;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        hi    <= pendHi;
                        lo    <= pendLo;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_scheduler.sv
// Self-checking bench for mdu_scheduler: vector table through a scoreboard plus multi-cycle corner sequences.
module tb_mdu_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic [3:0]  mul_op = 4'd0;
    logic [1:0]  mthilo = 2'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        d_uses_mdu = 1'b0;
    logic        busy;
    logic        stall_d;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

`ifdef MDU_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  mv;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expLat;
    } vecT;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } expT;

    vecT tbl[$];
    expT expQ[$];

    mdu_scheduler #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk),
        .reset(reset),
        .op_valid(op_valid),
        .mul_op(mul_op),
        .mthilo(mthilo),
        .src_a(src_a),
        .src_b(src_b),
        .d_uses_mdu(d_uses_mdu),
        .busy(busy),
        .stall_d(stall_d),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        op_valid = 1'b0;
        mul_op   = 4'd0;
        mthilo   = 2'd0;
    endtask

    // Issue one op, count busy cycles, then compare against the scoreboard head.
    task automatic runVec(input vecT v, input string tag);
        int  n;
        expT e;
        @(negedge clk);
        op_valid = 1'b1;
        mul_op   = v.op;
        mthilo   = v.mv;
        src_a    = v.a;
        src_b    = v.b;
        expQ.push_back('{v.expHi, v.expLo, v.expLat});
        #1 n = busy ? 1 : 0;
        @(negedge clk);
        clearInputs();
        #1;
        for (int k = 0; k < 40 && busy; k++) begin
            n++;
            @(negedge clk);
            #1;
        end
        e = expQ.pop_front();
        check({tag, " busyCycles"}, 32'(n), 32'(e.lat));
        check({tag, " hi"}, hi, e.hi);
        check({tag, " lo"}, lo, e.lo);
    endtask

    initial begin
        int n;
        tbl.push_back('{4'd1, 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5});
        tbl.push_back('{4'd4, 2'd0, 32'd7, 32'd2, 32'd1, 32'd3, 10});
        tbl.push_back('{4'd3, 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
        tbl.push_back('{4'd3, 2'd0, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 10});
        tbl.push_back('{4'd3, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10});
        tbl.push_back('{4'd2, 2'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 5});
        tbl.push_back('{4'd4, 2'd0, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 10});
        tbl.push_back('{4'd3, 2'd0, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10});
        tbl.push_back('{4'd0, 2'd1, 32'h1234, 32'd0, 32'd1, 32'h1234, 0});
        tbl.push_back('{4'd0, 2'd2, 32'hABCD, 32'd0, 32'hABCD, 32'h1234, 0});
        tbl.push_back('{4'd1, 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 5});
        tbl.push_back('{4'd1, 2'd1, 32'd2, 32'd3, 32'd0, 32'd6, 5});
        tbl.push_back('{4'd9, 2'd0, 32'd55, 32'd1, 32'd0, 32'd6, 0});
        tbl.push_back('{4'd0, 2'd1, 32'd10, 32'd0, 32'd0, 32'd10, 0});
        tbl.push_back('{4'd5, 2'd0, 32'd2, 32'd3, 32'd0, MADD ? 32'd16 : 32'd10, MADD ? 5 : 0});
        tbl.push_back('{4'd7, 2'd0, 32'd2, 32'd3, 32'd0, 32'd10, MADD ? 5 : 0});
        tbl.push_back('{4'd8, 2'd0, 32'd1, 32'd11, MADD ? 32'hFFFF_FFFF : 32'd0,
                        MADD ? 32'hFFFF_FFFF : 32'd10, MADD ? 5 : 0});
        tbl.push_back('{4'd0, 2'd2, 32'd0, 32'd0, 32'd0, MADD ? 32'hFFFF_FFFF : 32'd10, 0});

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset stall_d", 32'(stall_d), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) runVec(tbl[i], $sformatf("vec%0d", i));

        // stall_d follows busy while ID holds an MDU-using instruction
        @(negedge clk);
        d_uses_mdu = 1'b1;
        op_valid = 1'b1; mul_op = 4'd1; src_a = 32'd4; src_b = 32'd5;
        #1 check("stall c0", 32'(stall_d), 32'd1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            clearInputs();
            #1 check($sformatf("stall c%0d", c), 32'(stall_d), (c < 5) ? 32'd1 : 32'd0);
        end
        check("stall mult lo", lo, 32'd20);
        check("stall mult hi", hi, 32'd0);
        d_uses_mdu = 1'b0;

        // Moves and MDU ops arriving mid-run are ignored
        @(negedge clk);
        op_valid = 1'b1; mul_op = 4'd3; mthilo = 2'd0; src_a = 32'd100; src_b = 32'd7;
        #1 n = busy ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            clearInputs();
            if (k == 1) begin
                op_valid = 1'b1; mul_op = 4'd1; mthilo = 2'd1; src_a = 32'd5; src_b = 32'd5;
            end
            #1;
            if (!busy) break;
            n++;
        end
        check("midrun busyCycles", 32'(n), 32'd10);
        check("midrun hi", hi, 32'd2);
        check("midrun lo", lo, 32'd14);

        // Async reset mid-divide discards the pending result at once
        @(negedge clk);
        op_valid = 1'b1; mul_op = 4'd3; src_a = 32'd9; src_b = 32'd2;
        @(negedge clk);
        clearInputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid hi", hi, 32'd0);
        check("rstmid lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        runVec('{4'd1, 2'd0, 32'd4, 32'd5, 32'd0, 32'd20, 5}, "postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
